// File: rtl/seg7_reader.sv
// Seven-segment bus reader: filters glitches on the multiplexed segment/digit lines and
// reassembles the four displayed hex digits into a 16-bit word with a completion pulse.
module seg7_reader #(
  parameter int unsigned STABLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:6]  seg,
  input  logic [3:0]  dig,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  bad
);

  localparam int unsigned CntW = $clog2(STABLE + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(STABLE);
  localparam cnt_t CntCap = cnt_t'(STABLE - 1);

  logic [3:0]       s_dig_q;
  logic [0:6]       s_seg_q;
  cnt_t             cnt_q, cnt_d;
  logic [3:0][3:0]  nib_q, nib_d;
  logic [3:0]       badacc_q, badacc_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      value_d;
  logic [3:0]       bad_d;
  logic             valid_d;

  logic             same;
  logic             capture;
  logic             onehot;
  logic [3:0]       dec_nib;
  logic             dec_ill;

  assign same    = (dig == s_dig_q) && (seg == s_seg_q);
  assign capture = same && (cnt_q == CntCap);
  assign onehot  = (s_dig_q != 4'd0) && ((s_dig_q & (s_dig_q - 4'd1)) == 4'd0);

  // Pattern literals read a..g left to right, matching seg[0]=a as the MSB.
  always_comb begin
    dec_nib = 4'h0;
    dec_ill = 1'b0;
    case (s_seg_q)
      7'b1111110: dec_nib = 4'h0;
      7'b0110000: dec_nib = 4'h1;
      7'b1101101: dec_nib = 4'h2;
      7'b1111001: dec_nib = 4'h3;
      7'b0110011: dec_nib = 4'h4;
      7'b1011011: dec_nib = 4'h5;
      7'b1011111: dec_nib = 4'h6;
      7'b1110000: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1111011: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b0011111: dec_nib = 4'hB;
      7'b1001110: dec_nib = 4'hC;
      7'b0111101: dec_nib = 4'hD;
      7'b1001111: dec_nib = 4'hE;
      7'b1000111: dec_nib = 4'hF;
      default:    dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    nib_d    = nib_q;
    badacc_d = badacc_q;
    seen_d   = seen_q;
    value_d  = value;
    bad_d    = bad;
    valid_d  = 1'b0;
    if (capture && onehot) begin
      for (int i = 0; i < 4; i++) begin
        if (s_dig_q[i]) begin
          nib_d[i]    = dec_nib;
          badacc_d[i] = dec_ill;
          seen_d[i]   = 1'b1;
        end
      end
      // Completion merges the digit captured on this very edge.
      if (seen_d == 4'hF) begin
        value_d  = nib_d;
        bad_d    = badacc_d;
        valid_d  = 1'b1;
        seen_d   = 4'h0;
        badacc_d = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_dig_q  <= '0;
      s_seg_q  <= '0;
      cnt_q    <= '0;
      nib_q    <= '0;
      badacc_q <= '0;
      seen_q   <= '0;
      value    <= '0;
      bad      <= '0;
      valid    <= 1'b0;
    end else begin
      s_dig_q  <= dig;
      s_seg_q  <= seg;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      badacc_q <= badacc_d;
      seen_q   <= seen_d;
      value    <= value_d;
      bad      <= bad_d;
      valid    <= valid_d;
    end
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Decodes a multiplexed 4-digit seven-segment display bus back into a 16-bit hex value. The block is the decoding counterpart of the team's hex-to-segment decoder: it samples the segment lines and one-hot digit strobes, filters out switching glitches, and maps each segment pattern back to its nibble. When all four digits have been captured, it presents the assembled word with a one-cycle valid pulse. It sits on the display-monitor / self-check path, next to the display driver.

## Interface

- STABLE, 4: number of consecutive identical registered samples required before a digit is captured. Legal range is 2..255; the counter width is sized to hold STABLE.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- seg  input  [0:6]  segment lines a..g; seg[0]=a, seg[6]=g; 1 = lit. Synchronous to clk.
- dig  input  [3:0]  digit strobes, active-high, one-hot; dig[0] = least-significant digit.
- value  output  [15:0]  last completed frame; nibble i is taken from digit i.
- valid  output  1  one-cycle pulse when value/bad are updated.
- bad  output  [3:0]  per-digit flag for the completed frame; 1 = that digit showed an illegal pattern.

## Operation

- Legal patterns (seg a..g → nibble):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3
  - 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1111011=9, 1110111=A, 0011111=b
  - 1001110=C, 0111101=d, 1001111=E, 1000111=F
- Any other pattern, including blank 0000000, is illegal. An illegal pattern decodes to nibble 0 with the digit's bad bit set.
- Sample register s holds {dig, seg}. It is loaded every edge.
- Stability counter cnt:
  - If the incoming {dig, seg} differs from s, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE.
- Capture happens on the edge where cnt goes from STABLE-1 to STABLE. It therefore happens at most once per stable window, and a new window needs an input change.
- At capture:
  - If s.dig is not one-hot (0000 or more than one bit set), the capture is ignored; no state changes.
  - Otherwise, for digit i: nib[i] <= decode, badacc[i] <= illegal, seen[i] <= 1.
- If a digit is captured again before the frame completes, the latest capture wins (nib and badacc are overwritten).
- Frame completion: if (seen | capture bit) == 4'b1111 at a capture edge, then on that same edge:
  - value <= merged nibbles, including the one being captured;
  - bad <= merged badacc;
  - valid <= 1;
  - seen and badacc clear to 0.
- value and bad hold their contents until the next completion.
- valid is 0 on every edge that does not complete a frame.

## Timing

- Reset values: value=16'h0000, valid=0, bad=4'b0000. Internal state also resets: seen=0, badacc=0, nib=0, cnt=0, s=0. Because s.dig=0000 after reset, no capture can come from the reset state.
- Reset asserted mid-frame discards the partial frame immediately. After release, all four digits must be captured again.
- Latency: inputs change before edge k and are then held. cnt reaches STABLE at edge k+STABLE, so the capture (and valid, if it completes the frame) is visible after edge k+STABLE. With STABLE=4 this is k+4.
- An input held for fewer than STABLE+1 edges (counting edge k) is never captured.
- Re-strobing the same digit with an identical pattern without any intervening change gives no new capture. The scan sequence must change dig or seg.
- No backpressure: valid is a pulse, and the consumer must take value/bad in that cycle or read the held registers afterwards.

## Test plan

- Scan 0x3A5F, each digit held 6 cycles, in order dig 0001/1000111, 0010/1011011, 0100/1110111, 1000/1111001 → exactly one valid pulse, value=16'h3A5F, bad=4'b0000, 4 edges after the last digit change.
- Glitch filter: digit 0 pattern held only 3 cycles (STABLE=4) before changing to digit 1 → digit 0 is not seen. Completing digits 1..3 gives no valid until digit 0 is held at least 5 edges.
- Illegal pattern 1111100 on dig 0100 while the other digits show 8 → value=16'h8088, bad=4'b0100.
- dig=0011 and dig=0000 held 10 cycles each, mixed into the scan → ignored. The frame completes only from the one-hot strobes, and the value is unaffected.
- Reset pulse (rst_n low 1 cycle) after 2 digits are captured → valid=0, value=0, bad=0. A full 4-digit rescan of 0x1234 is then required, giving value=16'h1234.
- Overwrite and round-trip:
  - Digit 0 captured as 1, then as 7, before digits 1..3 → value[3:0]=7.
  - Sweep all 16 legal patterns on each digit → each nibble decodes correctly with bad=0.
